// File: rtl/apb_uart_regs_pkg.sv
// rtl/apb_uart_regs_pkg.sv - register map constants and CTRL layout for the UART APB register bank
package uart_regs_pkg;

  // Word offsets, i.e. paddr[7:2]
  localparam logic [5:0] ADDR_TXDATA  = 6'h00;
  localparam logic [5:0] ADDR_RXDATA  = 6'h01;
  localparam logic [5:0] ADDR_STATUS  = 6'h02;
  localparam logic [5:0] ADDR_CTRL    = 6'h03;
  localparam logic [5:0] ADDR_BAUDDIV = 6'h04;
  localparam logic [5:0] ADDR_INTCLR  = 6'h05;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_TX_OVF   = 5;

  localparam int CTRL_W = 5;

  typedef struct packed {
    logic err_ie;
    logic rx_ie;
    logic tx_ie;
    logic rx_en;
    logic tx_en;
  } ctrl_t;

  function automatic logic [3:0] sat_count4(input logic [31:0] cnt);
    return (cnt > 32'd15) ? 4'hF : cnt[3:0];
  endfunction

endpackage

// File: rtl/apb_uart_regs_if.sv
// rtl/apb_uart_regs_if.sv - APB bus bundle between the agent and the UART register completer
interface apb_uart_regs_if;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        psel;
  logic        penable;
  logic        pwrite;

  modport master (output paddr, pwdata, psel, penable, pwrite, input prdata);
  modport slave  (input paddr, pwdata, psel, penable, pwrite, output prdata);
endinterface

// File: rtl/apb_uart_regs_fifo.sv
// rtl/apb_uart_regs_fifo.sv - synchronous FIFO; push while full is accepted when a pop happens in the same cycle
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer MSB distinguishes full from empty when the slot indices match
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count   = r_wr_ptr - r_rd_ptr;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/apb_uart_regs.sv
// rtl/apb_uart_regs.sv - APB completer for the UART: CTRL/BAUDDIV/STATUS registers, TX and RX byte FIFOs, interrupt
module apb_uart_regs
  import uart_regs_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] BAUD_RST   = 16'd54
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_uart_regs_if.slave       apb,
  output logic                 uart_int,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 tx_en,
  output logic                 rx_en,
  output logic [15:0]          baud_div
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ctrl_t       r_ctrl;
  logic [15:0] r_baud;
  logic [31:0] r_prdata;
  logic        r_rx_ovr;
  logic        r_tx_ovf;
  logic        r_uart_int;

  logic [5:0]  w_addr;
  logic        w_setup_rd;
  logic        w_wr;
  logic        w_intclr;
  logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
  logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic [7:0]  w_rx_head;
  logic [CW-1:0] w_tx_count, w_rx_count;
  logic        w_tx_ovf_set, w_rx_ovr_set;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_addr     = apb.paddr[7:2];
  assign w_setup_rd = apb.psel & ~apb.penable & ~apb.pwrite;
  assign w_wr       = apb.psel & apb.penable & apb.pwrite;
  assign w_intclr   = w_wr & (w_addr == ADDR_INTCLR);

  assign w_tx_push = w_wr & (w_addr == ADDR_TXDATA);
  assign w_tx_pop  = tx_valid & tx_ready;
  // RXDATA pops on the setup edge so the byte lands in prdata for the access phase
  assign w_rx_pop  = w_setup_rd & (w_addr == ADDR_RXDATA);
  assign w_rx_push = rx_valid & r_ctrl.rx_en;

  assign w_tx_ovf_set = w_tx_push & w_tx_full & ~w_tx_pop;
  assign w_rx_ovr_set = w_rx_push & w_rx_full & ~w_rx_pop;

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(pclk), .rst_n(presetn),
    .i_push(w_tx_push), .i_data(apb.pwdata[7:0]), .i_pop(w_tx_pop),
    .o_head(tx_data), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(pclk), .rst_n(presetn),
    .i_push(w_rx_push), .i_data(rx_data), .i_pop(w_rx_pop),
    .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_FULL]  = w_rx_full;
    w_status[ST_RX_EMPTY] = w_rx_empty;
    w_status[ST_RX_OVR]   = r_rx_ovr;
    w_status[ST_TX_OVF]   = r_tx_ovf;
    w_status[11:8]        = sat_count4(32'(w_rx_count));
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_RXDATA:              w_rdata = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      ADDR_STATUS, ADDR_INTCLR: w_rdata = w_status;
      ADDR_CTRL:                w_rdata = {{(32-CTRL_W){1'b0}}, r_ctrl};
      ADDR_BAUDDIV:             w_rdata = {16'd0, r_baud};
      default:                  w_rdata = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_ctrl     <= '0;
      r_baud     <= BAUD_RST;
      r_prdata   <= '0;
      r_rx_ovr   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_uart_int <= 1'b0;
    end else begin
      if (w_setup_rd) r_prdata <= w_rdata;
      if (w_wr && (w_addr == ADDR_CTRL))    r_ctrl <= ctrl_t'(apb.pwdata[CTRL_W-1:0]);
      if (w_wr && (w_addr == ADDR_BAUDDIV)) r_baud <= apb.pwdata[15:0];
      // A new event in the same cycle as its W1C clear wins
      r_rx_ovr <= w_rx_ovr_set | (r_rx_ovr & ~(w_intclr & apb.pwdata[ST_RX_OVR]));
      r_tx_ovf <= w_tx_ovf_set | (r_tx_ovf & ~(w_intclr & apb.pwdata[ST_TX_OVF]));
      r_uart_int <= (r_ctrl.tx_ie & w_tx_empty) | (r_ctrl.rx_ie & ~w_rx_empty) |
                    (r_ctrl.err_ie & (r_rx_ovr | r_tx_ovf));
    end
  end

  assign apb.prdata = r_prdata;
  assign uart_int   = r_uart_int;
  assign tx_valid   = ~w_tx_empty & r_ctrl.tx_en;
  assign tx_en      = r_ctrl.tx_en;
  assign rx_en      = r_ctrl.rx_en;
  assign baud_div   = r_baud;

  assign w_unused = ^{apb.paddr[31:8], apb.paddr[1:0], apb.pwdata[31:16], w_tx_count};
endmodule

// File: tb/tb_apb_uart_regs.sv
// tb/tb_apb_uart_regs.sv - self-checking bench for apb_uart_regs against a queue-based register model
module tb_apb_uart_regs;
  localparam int DEPTH = 8;

  logic        pclk;
  logic        presetn;
  logic        uart_int;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_en;
  logic        rx_en;
  logic [15:0] baud_div;

  apb_uart_regs_if bus();

  apb_uart_regs #(.FIFO_DEPTH(DEPTH), .BAUD_RST(16'd54)) dut (
    .pclk(pclk), .presetn(presetn), .apb(bus.slave), .uart_int(uart_int),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_en(tx_en), .rx_en(rx_en),
    .baud_div(baud_div)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  logic [4:0]  m_ctrl;
  logic [15:0] m_baud;
  bit          m_ovr, m_ovf;
  logic [31:0] m_prdata;
  int          n_checks, n_errors;
  bit          rand_side;
  int          tx_pops;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    txq.delete(); rxq.delete();
    m_ctrl = '0; m_baud = 16'd54; m_ovr = 0; m_ovf = 0; m_prdata = '0;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s = '0;
    s[0] = (txq.size() == DEPTH);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == DEPTH);
    s[3] = (rxq.size() == 0);
    s[4] = m_ovr;
    s[5] = m_ovf;
    s[11:8] = (rxq.size() > 15) ? 4'd15 : 4'(rxq.size());
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic [5:0] a);
    case (a)
      6'd1:       return (rxq.size() > 0) ? {24'd0, rxq[0]} : 32'd0;
      6'd2, 6'd5: return m_status();
      6'd3:       return {27'd0, m_ctrl};
      6'd4:       return {16'd0, m_baud};
      default:    return 32'd0;
    endcase
  endfunction

  // One clock: inputs already driven; advance model, cross the edge, compare.
  task automatic cycle();
    logic [5:0]  a;
    bit          rd_setup, wr, exp_tv, txp, rxp, exp_int;
    logic [31:0] exp_rd;
    if (rand_side) begin
      rx_valid = ($urandom_range(0, 3) == 0);
      rx_data  = 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
    end
    #1;
    exp_tv = m_ctrl[0] && (txq.size() > 0);
    check("tx_valid", tx_valid, exp_tv);
    if (exp_tv) check("tx_data", tx_data, txq[0]);
    if (tx_valid && tx_ready) tx_pops++;
    a        = bus.paddr[7:2];
    rd_setup = bus.psel && !bus.penable && !bus.pwrite;
    wr       = bus.psel && bus.penable && bus.pwrite;
    exp_int  = (m_ctrl[2] && txq.size() == 0) || (m_ctrl[3] && rxq.size() != 0) ||
               (m_ctrl[4] && (m_ovr || m_ovf));
    exp_rd   = m_read(a);
    txp      = exp_tv && tx_ready;
    rxp      = rd_setup && (a == 6'd1) && (rxq.size() > 0);
    if (txp) void'(txq.pop_front());
    if (rxp) void'(rxq.pop_front());
    if (wr) begin
      case (a)
        6'd0: if (txq.size() < DEPTH) txq.push_back(bus.pwdata[7:0]); else m_ovf = 1;
        6'd3: m_ctrl = bus.pwdata[4:0];
        6'd4: m_baud = bus.pwdata[15:0];
        6'd5: begin
          if (bus.pwdata[4]) m_ovr = 0;
          if (bus.pwdata[5]) m_ovf = 0;
        end
        default: ;
      endcase
    end
    if (rx_valid && m_ctrl[1]) begin
      if (rxq.size() < DEPTH) rxq.push_back(rx_data); else m_ovr = 1;
    end
    @(posedge pclk);
    @(negedge pclk);
    if (rd_setup) begin
      m_prdata = exp_rd;
      check("prdata", bus.prdata, exp_rd);
    end
    check("uart_int", uart_int, exp_int);
    check("ctrl_out", {30'd0, rx_en, tx_en}, {30'd0, m_ctrl[1], m_ctrl[0]});
    check("baud_div", baud_div, m_baud);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = addr; bus.pwdata = data;
    cycle();
    bus.penable = 1;
    cycle();
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = addr;
    cycle();
    data = bus.prdata;
    bus.penable = 1;
    cycle();
    check("prdata_hold", bus.prdata, m_prdata);
    bus.psel = 0; bus.penable = 0;
  endtask

  task automatic strobe_rx(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    cycle();
    rx_valid = 0;
  endtask

  logic [31:0] rd;

  initial begin
    n_checks = 0; n_errors = 0; rand_side = 0; tx_pops = 0;
    presetn = 0; tx_ready = 0; rx_valid = 0; rx_data = 0;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    model_reset();
    repeat (3) @(negedge pclk);
    check("rst_prdata", bus.prdata, 32'd0);
    check("rst_int", uart_int, 32'd0);
    presetn = 1;
    idle(1);

    apb_read(32'h10, rd); check("baud_rst", rd, 32'h36);
    apb_read(32'h0C, rd); check("ctrl_rst", rd, 32'h0);
    apb_read(32'h08, rd); check("status_rst", rd, 32'h0A);

    apb_write(32'h0C, 32'h1);
    apb_write(32'h00, 32'hA5);
    apb_write(32'h00, 32'h3C);
    tx_ready = 1;
    #1 check("tx_first", tx_data, 32'hA5);
    cycle();
    check("tx_second", tx_data, 32'h3C);
    cycle();
    tx_ready = 0;
    apb_read(32'h08, rd); check("tx_empty_again", rd[1], 32'd1);

    apb_write(32'h0C, 32'h2);
    for (int i = 1; i <= 9; i++) strobe_rx(8'(i));
    apb_read(32'h08, rd); check("rx_full_ovr", rd, 32'h816);
    for (int i = 1; i <= 8; i++) begin
      apb_read(32'h04, rd); check("rx_byte", rd, 32'(i));
    end
    apb_read(32'h04, rd); check("rx_empty_read", rd, 32'h0);
    apb_write(32'h14, 32'h10);

    apb_write(32'h0C, 32'h1A);
    for (int i = 0; i < 9; i++) strobe_rx(8'(8'h40 + i));
    idle(1);
    check("int_on_ovr", uart_int, 32'd1);
    apb_write(32'h14, 32'h10);
    for (int i = 0; i < 8; i++) apb_read(32'h04, rd);
    idle(2);
    check("int_cleared", uart_int, 32'd0);

    apb_write(32'h0C, 32'h0);
    tx_ready = 1;
    for (int i = 0; i < 9; i++) apb_write(32'h00, 32'(8'h80 + i));
    #1 check("tx_valid_gated", tx_valid, 32'd0);
    apb_read(32'h08, rd); check("tx_ovf_full", {rd[5], rd[0]}, 32'd3);
    tx_pops = 0;
    apb_write(32'h0C, 32'h1);
    idle(15);
    check("tx_pop_count", tx_pops, 32'd8);
    tx_ready = 0;
    apb_write(32'h14, 32'h30);

    rand_side = 1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] addr;
      addr = {24'($urandom), 6'($urandom_range(0, 7)), 2'($urandom)};
      if ($urandom_range(0, 1) == 1) apb_write(addr, $urandom);
      else apb_read(addr, rd);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_side = 0; rx_valid = 0; tx_ready = 0;

    apb_write(32'h0C, 32'h2);
    for (int i = 0; i < 3; i++) strobe_rx(8'(8'h70 + i));
    apb_write(32'h00, 32'h55);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 0; bus.paddr = 32'h04;
    cycle();
    bus.penable = 1;
    #2 presetn = 0;
    #1;
    model_reset();
    check("arst_prdata", bus.prdata, 32'd0);
    check("arst_ctrl", {30'd0, rx_en, tx_en}, 32'd0);
    check("arst_baud", baud_div, 32'h36);
    check("arst_int", uart_int, 32'd0);
    check("arst_tx_valid", tx_valid, 32'd0);
    bus.psel = 0; bus.penable = 0;
    @(negedge pclk);
    presetn = 1;
    idle(1);
    apb_read(32'h08, rd); check("status_after_rst", rd, 32'h0A);
    apb_read(32'h04, rd); check("rx_after_rst", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/apb_uart_regs.md
Name: apb_uart_regs

Overview:
APB completer for the UART peripheral: the slave side of the bus that the APB agent drives. Decodes zero-wait-state APB transfers into a register bank (control, baud divisor, status, interrupts). Buffers transmit bytes toward the UART TX core and received bytes from the UART RX core in two small FIFOs. Raises uart_int from maskable status conditions.

Parameters:
FIFO_DEPTH, 8, entries per TX and RX FIFO; power of two, >=2
BAUD_RST, 16'd54, reset value of the BAUDDIV register

Ports:
pclk  in  1  APB clock; only clock
presetn  in  1  async active-low reset
paddr  in  32  byte address; only paddr[7:2] decoded
pwdata  in  32  write data
prdata  out  32  read data, registered
psel  in  1  completer select
penable  in  1  access phase
pwrite  in  1  1=write, 0=read
uart_int  out  1  level interrupt, registered
tx_data  out  8  TX FIFO head byte
tx_valid  out  1  TX FIFO non-empty and tx_en set
tx_ready  in  1  TX core accepts head byte when tx_valid&tx_ready
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; no backpressure
tx_en  out  1  CTRL[0]
rx_en  out  1  CTRL[1]
baud_div  out  16  BAUDDIV[15:0]

Behaviour:
- Reset (async, presetn=0): prdata=0, uart_int=0, CTRL=0, BAUDDIV=BAUD_RST, both FIFOs empty, sticky flags clear. Reset mid-transfer aborts it; no partial push/pop.
- APB: no wait states, no error response. Setup = psel&~penable; access = psel&penable.
- Reads: prdata loaded at the setup-phase edge, valid for the whole access phase, holds until the next read setup.
- Writes: committed at the access-phase edge.
- Register map (offset):
  - 0x00 TXDATA, W: push pwdata[7:0]. If full, the byte is dropped and tx_ovf is set. Reads return 0.
  - 0x04 RXDATA, R: returns {24'b0, head}. The pop occurs at the same setup edge. If empty, returns 0 and does not pop.
  - 0x08 STATUS, R: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_ovr, [5] tx_ovf, [11:8] rx_count (saturates at 15).
  - 0x0C CTRL, RW: [0] tx_en, [1] rx_en, [2] tx_ie, [3] rx_ie, [4] err_ie. Other bits read 0.
  - 0x10 BAUDDIV, RW: [15:0].
  - 0x14 INTCLR, W1C: [4] clears rx_ovr, [5] clears tx_ovf. Reads return STATUS.
  - Unmapped: reads 0, writes ignored.
- RX path: rx_valid&rx_en pushes rx_data.
  - Full with no same-cycle pop: byte dropped, rx_ovr set.
  - Full with same-cycle pop: push accepted, no overrun.
  - rx_valid while rx_en=0: ignored.
- TX path: tx_valid = ~tx_empty & tx_en; tx_data = head.
  - tx_valid&tx_ready pops.
  - An APB push and a core pop in the same cycle are both honoured, including when full.
- Sticky flags: a set and a W1C clear in the same cycle leave the flag set.
- uart_int, registered (one-cycle lag): (tx_ie & tx_empty) | (rx_ie & ~rx_empty) | (err_ie & (rx_ovr | tx_ovf)).
- FIFO pointers use log2(FIFO_DEPTH)+1 bits; wrap-around is modular.

Decomposition:
- Package uart_regs_pkg: register offset localparams, CTRL/STATUS bit-index constants, a typedef struct for CTRL fields.
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH): push/pop, full/empty/count, same-cycle push+pop legal when full. Instantiated twice, for TX and RX.

Test Plan:
- Reset, then read BAUDDIV, CTRL, STATUS -> 0x36, 0x0, 0x0A (tx_empty, rx_empty).
- Write CTRL=0x1, push 0xA5 and 0x3C to TXDATA, hold tx_ready=1 -> tx_data 0xA5 then 0x3C on consecutive cycles; STATUS[1] returns to 1.
- CTRL=0x2, strobe rx_valid 9 times with 0x01..0x09 (depth 8) -> STATUS rx_full=1, rx_ovr=1. Eight RXDATA reads return 0x01..0x08; a ninth read returns 0.
- CTRL=0x1A, trigger rx_ovr -> uart_int=1 one cycle later. Write INTCLR=0x10 and drain RX -> uart_int=0.
- With tx_en=0, push 9 bytes -> tx_ovf=1, tx_valid stays 0. Set tx_en=1 -> exactly 8 bytes emitted.
- Assert presetn low mid-access of a RXDATA read with 3 bytes queued -> FIFOs empty, prdata=0, CTRL=0 immediately. After release, STATUS reads 0x0A.
